// File: rtl/tile_render_sched.sv
// Tile draw-request queue and sequencer for a restartable 32x32 tile renderer.
// Optional build macro TILE_SCHED_CLIP_EN discards off-screen tiles and counts them on clip_cnt_o.
module tile_render_sched #(
  parameter int DEPTH    = 4,
  parameter int TILE_PIX = 1024,
  parameter int ROM_LAT  = 2
`ifdef TILE_SCHED_CLIP_EN
  ,
  parameter int SCR_W    = 640,
  parameter int SCR_H    = 480
`endif
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [18:0]              req_tile_addr_i,
  input  logic [9:0]               req_top_i,
  input  logic [9:0]               req_left_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic                     r_start_o,
  output logic [18:0]              r_tile_addr_o,
  output logic [9:0]               r_top_o,
  output logic [9:0]               r_left_o,
  output logic                     r_busy_o,
  output logic                     done_o,
  output logic                     idle_o,
  output logic [$clog2(DEPTH):0]   q_level_o
`ifdef TILE_SCHED_CLIP_EN
  ,
  output logic [15:0]              clip_cnt_o
`endif
);

  localparam int AW         = $clog2(DEPTH);
  localparam int RUN_CYCLES = TILE_PIX + ROM_LAT;
  localparam int CW         = $clog2(RUN_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYCLES - 1);
  localparam int EW         = 39;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [18:0]     r_tile_addr_q;
  logic [9:0]      r_top_q;
  logic [9:0]      r_left_q;

  logic            empty_s, full_s, push_s, pop_s, load_s, discard_s, clip_s;
  logic [EW-1:0]   head_s;

  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready_o = !full_s && !flush_i;
  assign push_s      = req_valid_i && req_ready_o;
  assign head_s      = mem_q[rd_ptr_q[AW-1:0]];
  assign q_level_o   = wr_ptr_q - rd_ptr_q;

`ifdef TILE_SCHED_CLIP_EN
  localparam logic [9:0] SCR_W_L = 10'(SCR_W);
  localparam logic [9:0] SCR_H_L = 10'(SCR_H);
  assign clip_s = (head_s[19:10] >= SCR_H_L) || (head_s[9:0] >= SCR_W_L);
`else
  assign clip_s = 1'b0;
`endif

  // Next-state, counter and pop decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_s     = 1'b0;
    load_s    = 1'b0;
    discard_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && !hold_i && !flush_i) begin
          pop_s = 1'b1;
          if (clip_s) begin
            discard_s = 1'b1;
          end else begin
            load_s  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          // A clipped head is left for IDLE to discard so the pop costs its own cycle.
          if (!empty_s && !hold_i && !flush_i && !clip_s) begin
            pop_s  = 1'b1;
            load_s = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and tile cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO pointers; flush empties the queue and wins over push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      else        wr_ptr_q <= wr_ptr_q;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      else        rd_ptr_q <= rd_ptr_q;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {req_tile_addr_i, req_top_i, req_left_i};
    end else begin
      mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
    end
  end

  // Renderer parameters held for the whole tile and beyond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tile_addr_q <= '0;
      r_top_q       <= '0;
      r_left_q      <= '0;
    end else if (load_s) begin
      r_tile_addr_q <= head_s[38:20];
      r_top_q       <= head_s[19:10];
      r_left_q      <= head_s[9:0];
    end else begin
      r_tile_addr_q <= r_tile_addr_q;
      r_top_q       <= r_top_q;
      r_left_q      <= r_left_q;
    end
  end

`ifdef TILE_SCHED_CLIP_EN
  logic [15:0] clip_cnt_q;
  // Saturating count of discarded off-screen requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clip_cnt_q <= '0;
    end else if (discard_s && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end else begin
      clip_cnt_q <= clip_cnt_q;
    end
  end
  assign clip_cnt_o = clip_cnt_q;
`else
  logic unused_s;
  assign unused_s = discard_s;
`endif

  assign r_tile_addr_o = r_tile_addr_q;
  assign r_top_o       = r_top_q;
  assign r_left_o      = r_left_q;
  assign r_busy_o      = (state_q == ST_RUN);
  assign r_start_o     = (state_q == ST_RUN) && (cnt_q == '0);
  assign done_o        = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign idle_o        = (state_q == ST_IDLE) && empty_s;

endmodule

// File: tb/tb_tile_render_sched.sv
// Directed self-checking bench for tile_render_sched (default DEPTH=4, 1026-cycle tiles).
module tb_tile_render_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [18:0] req_tile_addr;
  logic [9:0]  req_top;
  logic [9:0]  req_left;
  logic        hold;
  logic        flush;
  logic        r_start;
  logic [18:0] r_tile_addr;
  logic [9:0]  r_top;
  logic [9:0]  r_left;
  logic        r_busy;
  logic        done;
  logic        idle;
  logic [2:0]  q_level;
`ifdef TILE_SCHED_CLIP_EN
  logic [15:0] clip_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  tile_render_sched dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_tile_addr_i (req_tile_addr),
    .req_top_i       (req_top),
    .req_left_i      (req_left),
    .hold_i          (hold),
    .flush_i         (flush),
    .r_start_o       (r_start),
    .r_tile_addr_o   (r_tile_addr),
    .r_top_o         (r_top),
    .r_left_o        (r_left),
    .r_busy_o        (r_busy),
    .done_o          (done),
    .idle_o          (idle),
    .q_level_o       (q_level)
`ifdef TILE_SCHED_CLIP_EN
    ,
    .clip_cnt_o      (clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present one request for one clock; returns at the following falling edge.
  task automatic push(input logic [18:0] a, input logic [9:0] t, input logic [9:0] l);
    req_valid = 1'b1; req_tile_addr = a; req_top = t; req_left = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called in a busy cycle; counts cycles until r_busy drops.
  task automatic run_busy(output int n, output int ndone, output int nstart,
                          output int last_start, output logic [18:0] last_addr);
    n = 0; ndone = 0; nstart = 0; last_start = -1; last_addr = '0;
    while (r_busy && n < 6000) begin
      if (done) ndone++;
      if (r_start) begin
        nstart++; last_start = n; last_addr = r_tile_addr;
      end
      n++;
      @(negedge clk);
    end
  endtask

  int n, nd, ns, ls, guard;
  logic [18:0] la;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_tile_addr = '0; req_top = '0; req_left = '0;
    hold = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", r_busy, 0);
    check("rst_start", r_start, 0);
    check("rst_done", done, 0);
    check("rst_idle", idle, 1);
    check("rst_level", q_level, 0);
    check("rst_ready", req_ready, 1);
    check("rst_addr", r_tile_addr, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single tile
    push(19'h00400, 10'd32, 10'd64);
    check("t1_level1", q_level, 1);
    check("t1_nostart", r_start, 0);
    @(negedge clk);
    check("t1_start", r_start, 1);
    check("t1_addr", r_tile_addr, 32'h400);
    check("t1_top", r_top, 32);
    check("t1_left", r_left, 64);
    run_busy(n, nd, ns, ls, la);
    check("t1_busy_cycles", n, 1026);
    check("t1_done_cnt", nd, 1);
    check("t1_idle", idle, 1);
    check("t1_addr_held", r_tile_addr, 32'h400);

    // 2: fill under hold, then back-to-back
    hold = 1'b1;
    push(19'h00001, 10'd0, 10'd0);
    push(19'h00002, 10'd0, 10'd32);
    push(19'h00003, 10'd0, 10'd64);
    push(19'h00004, 10'd0, 10'd96);
    check("t2_level4", q_level, 4);
    check("t2_ready0", req_ready, 0);
    push(19'h00005, 10'd0, 10'd128);
    check("t2_fifth_refused", q_level, 4);
    check("t2_hold_nobusy", r_busy, 0);
    hold = 1'b0;
    @(negedge clk);
    check("t2_start", r_start, 1);
    check("t2_level3", q_level, 3);
    run_busy(n, nd, ns, ls, la);
    check("t2_busy_cycles", n, 4104);
    check("t2_done_cnt", nd, 4);
    check("t2_start_cnt", ns, 4);
    check("t2_last_start", ls, 3078);
    check("t2_last_addr", la, 4);
    check("t2_idle", idle, 1);

    // 3: mid-tile flush
    hold = 1'b1;
    push(19'h00011, 10'd1, 10'd1);
    push(19'h00012, 10'd1, 10'd1);
    push(19'h00013, 10'd1, 10'd1);
    push(19'h00014, 10'd1, 10'd1);
    hold = 1'b0;
    @(negedge clk);
    check("t3_start", r_start, 1);
    repeat (99) @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1; req_tile_addr = 19'h00099;
    #1;
    check("t3_flush_ready0", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check("t3_level0", q_level, 0);
    check("t3_still_busy", r_busy, 1);
    run_busy(n, nd, ns, ls, la);
    check("t3_rest_cycles", n, 926);
    check("t3_done_cnt", nd, 1);
    check("t3_no_new_start", ns, 0);
    check("t3_idle", idle, 1);
    repeat (3) @(negedge clk);
    check("t3_stay_idle", r_busy, 0);

    // 4: full FIFO, push refused at the pop cycle
    push(19'h00020, 10'd2, 10'd2);
    push(19'h00021, 10'd2, 10'd2);
    push(19'h00022, 10'd2, 10'd2);
    push(19'h00023, 10'd2, 10'd2);
    push(19'h00024, 10'd2, 10'd2);
    check("t4_level4", q_level, 4);
    guard = 0;
    while (!done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("t4_done_seen", done, 1);
    check("t4_level_at_done", q_level, 4);
    check("t4_ready0", req_ready, 0);
    push(19'h00077, 10'd3, 10'd3);
    check("t4_level3", q_level, 3);
    check("t4_b2b_start", r_start, 1);
    check("t4_next_addr", r_tile_addr, 32'h21);

    // 5: reset mid-tile
    repeat (500) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t5_busy0", r_busy, 0);
    check("t5_level0", q_level, 0);
    check("t5_addr0", r_tile_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t5_idle", idle, 1);
    push(19'h00555, 10'd100, 10'd200);
    @(negedge clk);
    check("t5_start", r_start, 1);
    check("t5_addr", r_tile_addr, 32'h555);
    run_busy(n, nd, ns, ls, la);
    check("t5_busy_cycles", n, 1026);
    check("t5_done_cnt", nd, 1);

`ifdef TILE_SCHED_CLIP_EN
    // 6: off-screen request discarded
    push(19'h00600, 10'd0, 10'd640);
    push(19'h00601, 10'd0, 10'd0);
    check("t6_clip_cnt", clip_cnt, 1);
    check("t6_no_start_yet", r_start, 0);
    @(negedge clk);
    check("t6_start", r_start, 1);
    check("t6_addr", r_tile_addr, 32'h601);
    run_busy(n, nd, ns, ls, la);
    check("t6_one_start", ns, 1);
    check("t6_done_cnt", nd, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
